// File: rtl/fibo_seq_gen.sv
// -----------------------------------------------------------------------------
// fibo_seq_gen
//
// Fibonacci-type sequence generator: t(n+2) = t(n) + t(n+1), with runtime
// loadable seeds, a valid/ready output stream, a term index and a wrap flag
// marking the last representable term before the sequence restarts.
//
// Parameters:
//   WIDTH   term width in bits
//   IDX_W   index counter width (index wraps modulo 2^IDX_W)
//   SEED_A  reset value of the first seed
//   SEED_B  reset value of the second seed
//
// Ports:
//   clock      in   clock
//   reset      in   asynchronous, active-high reset
//   en         in   request to produce / advance terms
//   load       in   load seed_a/seed_b and flush the stream (highest priority)
//   seed_a     in   first seed, sampled when load=1
//   seed_b     in   second seed, sampled when load=1
//   out_ready  in   consumer accepts the current term
//   out_valid  out  out_data holds a valid term
//   out_data   out  current term
//   out_index  out  index of out_data since the last seed load / wrap
//   wrap       out  out_data is the last representable term (with out_valid)
//
// Build option:
//   FIBO_HOLD_EN  when defined, the generator parks in DONE after the wrap
//                 term is accepted and waits for load or reset; when
//                 undefined, the sequence restarts from the seeds at once.
// -----------------------------------------------------------------------------
module fibo_seq_gen #(
    parameter int unsigned          WIDTH  = 16,
    parameter int unsigned          IDX_W  = 8,
    parameter logic [WIDTH-1:0]     SEED_A = WIDTH'(0),
    parameter logic [WIDTH-1:0]     SEED_B = WIDTH'(1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic             wrap
);

`ifdef FIBO_HOLD_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_VALID = 2'd1, ST_DONE = 2'd2} state_t;
`else
    typedef enum logic {ST_IDLE = 1'b0, ST_VALID = 1'b1} state_t;
`endif

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q;      // seeds used on restart after a wrap
    logic [WIDTH-1:0] a_q, b_q;        // a: next term to emit, b: the one after
    logic             ovf_q;           // b_q is a truncated, unrepresentable sum
    logic [IDX_W-1:0] index_q;         // index of a_q
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [IDX_W-1:0] out_index_q;
    logic             wrap_q;

    // One extra bit so the carry out of the term sum becomes the overflow flag.
    logic [WIDTH:0]   sum_d;
    logic             transfer;
    logic             hold_stop;
    logic             advance;

    assign sum_d    = {1'b0, a_q} + {1'b0, b_q};
    assign transfer = (state_q == ST_VALID) && out_ready;

`ifdef FIBO_HOLD_EN
    // Accepting the wrap term parks the generator instead of restarting.
    assign hold_stop = transfer && wrap_q;
`else
    assign hold_stop = 1'b0;
`endif

    // A stalled term (out_ready=0) blocks advancing; en is ignored then.
    assign advance = en && !hold_stop &&
                     ((state_q == ST_IDLE) || transfer);

    // NOTE: reset is in the sensitivity list so it acts without a clock edge;
    // every register, including the seed pair, gets a defined reset value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sa_q        <= SEED_A;
            sb_q        <= SEED_B;
            a_q         <= SEED_A;
            b_q         <= SEED_B;
            ovf_q       <= 1'b0;
            index_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            wrap_q      <= 1'b0;
        end else if (load) begin
            // NOTE: non-blocking assignments everywhere in clocked logic, so
            // every right-hand side sees the pre-edge register values.
            sa_q        <= seed_a;
            sb_q        <= seed_b;
            a_q         <= seed_a;
            b_q         <= seed_b;
            ovf_q       <= 1'b0;
            index_q     <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            state_q     <= ST_IDLE;
        end else if (advance) begin
            out_data_q  <= a_q;
            out_index_q <= index_q;
            wrap_q      <= ovf_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_VALID;
            if (ovf_q) begin
                // a_q was the last representable term: restart from the seeds.
                a_q     <= sa_q;
                b_q     <= sb_q;
                ovf_q   <= 1'b0;
                index_q <= '0;
            end else begin
                a_q     <= b_q;
                b_q     <= sum_d[WIDTH-1:0];
                ovf_q   <= sum_d[WIDTH];
                index_q <= index_q + IDX_W'(1);
            end
        end else if (transfer) begin
            // Term accepted with nothing new requested; data fields hold.
            out_valid_q <= 1'b0;
`ifdef FIBO_HOLD_EN
            state_q     <= hold_stop ? ST_DONE : ST_IDLE;
`else
            state_q     <= ST_IDLE;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_fibo_seq_gen.sv
// -----------------------------------------------------------------------------
// tb_fibo_seq_gen
//
// Bench for fibo_seq_gen: a 16-bit instance driven from a vector table plus
// hand-written sequences (full Fibonacci run to the wrap term, asynchronous
// reset mid-stream), and an 8-bit instance free-running through its wrap.
// -----------------------------------------------------------------------------
module tb_fibo_seq_gen;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        en = 1'b0, load = 1'b0, out_ready = 1'b0;
    logic [15:0] seed_a = '0, seed_b = '0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_index;
    logic        wrap;

    logic        en8 = 1'b0, load8 = 1'b0, ready8 = 1'b0;
    logic [7:0]  seed_a8 = '0, seed_b8 = '0;
    logic        valid8;
    logic [7:0]  data8;
    logic [7:0]  index8;
    logic        wrap8;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    fibo_seq_gen #(.WIDTH(16), .IDX_W(8)) dut (
        .clock(clock), .reset(reset), .en(en), .load(load),
        .seed_a(seed_a), .seed_b(seed_b), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .wrap(wrap)
    );

    fibo_seq_gen #(.WIDTH(8), .IDX_W(8)) dut8 (
        .clock(clock), .reset(reset), .en(en8), .load(load8),
        .seed_a(seed_a8), .seed_b(seed_b8), .out_ready(ready8),
        .out_valid(valid8), .out_data(data8), .out_index(index8),
        .wrap(wrap8)
    );

    typedef struct {
        logic        en;
        logic        load;
        logic        rdy;
        logic [15:0] sa;
        logic [15:0] sb;
        logic        chk_data;   // out_data/out_index are not checked after a load
        logic        v;
        logic [15:0] d;
        logic [7:0]  i;
        logic        w;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic e, input logic l, input logic r,
                                input logic [15:0] sa, input logic [15:0] sb,
                                input logic cd, input logic v, input logic [15:0] d,
                                input logic [7:0] i, input logic w);
        vec_t x;
        x.en = e; x.load = l; x.rdy = r; x.sa = sa; x.sb = sb;
        x.chk_data = cd; x.v = v; x.d = d; x.i = i; x.w = w;
        return x;
    endfunction

    // Inputs are driven 1 time unit after a rising edge; outputs are sampled
    // 1 time unit after the following rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check16(input string tag, input logic v, input logic [15:0] d,
                           input logic [7:0] i, input logic w, input logic cd);
        check({tag, " valid"}, 32'(out_valid), 32'(v));
        check({tag, " wrap"}, 32'(wrap), 32'(w));
        if (cd) begin
            check({tag, " data"}, 32'(out_data), 32'(d));
            check({tag, " index"}, 32'(out_index), 32'(i));
        end
    endtask

    initial begin
        // Table: en toggling, stall on 13, Lucas load during a stall,
        // load coinciding with a transfer.
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 1, 0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  1, 2, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  2, 3, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  3, 4, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  5, 5, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  8, 6, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1, 13, 7, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 13, 7, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 13, 7, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 1, 13, 7, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1, 21, 8, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 21, 8, 0));
        vecs.push_back(mk(1, 1, 0, 2, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  2, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  1, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  3, 2, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  4, 3, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  7, 4, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1, 11, 5, 0));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 5, 8, 0, 0,  0, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  5, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1,  8, 1, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 1, 13, 2, 0));

        // Reset state.
        #2 reset = 1'b1;
        #10;
        check16("reset", 1'b0, 16'd0, 8'd0, 1'b0, 1'b1);
        check("reset8 valid", 32'(valid8), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            en = vecs[k].en; load = vecs[k].load; out_ready = vecs[k].rdy;
            seed_a = vecs[k].sa; seed_b = vecs[k].sb;
            step();
            check16($sformatf("vec%0d", k), vecs[k].v, vecs[k].d, vecs[k].i,
                    vecs[k].w, vecs[k].chk_data);
        end

        // Full 16-bit Fibonacci run up to the wrap term and the restart.
        en = 1'b0; load = 1'b1; out_ready = 1'b1; seed_a = 16'd0; seed_b = 16'd1;
        step();
        check("full load valid", 32'(out_valid), 32'd0);
        load = 1'b0; en = 1'b1;
        begin
            int fa, fb, ft;
            fa = 0; fb = 1;
            for (int k = 0; k <= 24; k++) begin
                step();
                check16($sformatf("fib%0d", k), 1'b1, 16'(fa), 8'(k), (k == 24), 1'b1);
                ft = fa + fb; fa = fb; fb = ft;
            end
        end
        step();
        check16("fib restart0", 1'b1, 16'd0, 8'd0, 1'b0, 1'b1);
        step();
        check16("fib restart1", 1'b1, 16'd1, 8'd1, 1'b0, 1'b1);

        // Asynchronous reset while term 55 (index 10) is presented.
        en = 1'b0; load = 1'b1;
        step();
        load = 1'b0; en = 1'b1;
        for (int k = 0; k < 11; k++) step();
        check16("pre-reset", 1'b1, 16'd55, 8'd10, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1;
        check16("async reset", 1'b0, 16'd0, 8'd0, 1'b0, 1'b1);
        en = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        en = 1'b1;
        step();
        check16("post-reset", 1'b1, 16'd0, 8'd0, 1'b0, 1'b1);
        en = 1'b0;

        // 8-bit instance: 0..233, wrap on 233 (144+233 overflows), then 0.
        en8 = 1'b1; ready8 = 1'b1;
        begin
            int fa, fb, ft;
            fa = 0; fb = 1;
            for (int k = 0; k <= 13; k++) begin
                step();
                check($sformatf("w8 data%0d", k), 32'(data8), 32'(fa));
                check($sformatf("w8 index%0d", k), 32'(index8), 32'(k));
                check($sformatf("w8 wrap%0d", k), 32'(wrap8), 32'(k == 13));
                ft = fa + fb; fa = fb; fb = ft;
            end
        end
        step();
        check("w8 restart valid", 32'(valid8), 32'd1);
        check("w8 restart data", 32'(data8), 32'd0);
        check("w8 restart index", 32'(index8), 32'd0);
        check("w8 restart wrap", 32'(wrap8), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fibo_seq_gen.md
# fibo_seq_gen

Parametrised Fibonacci-type sequence generator with a valid/ready output stream, runtime-loadable seeds, term index output and overflow-driven wrap. It replaces the fixed 16-bit free-running generator in the multi-clock datapath. It feeds downstream consumers that may apply backpressure. Any additive recurrence t(n+2)=t(n)+t(n+1) is supported, e.g. Fibonacci with seeds 0,1 or Lucas with seeds 2,1.

## Interface
- WIDTH, 16, term width in bits
- IDX_W, 8, index counter width
- SEED_A, 0, reset value of the first seed
- SEED_B, 1, reset value of the second seed

- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- en  in  1  request to produce or advance terms
- load  in  1  load new seeds and flush the stream
- seed_a  in  WIDTH  first seed, sampled when load=1
- seed_b  in  WIDTH  second seed, sampled when load=1
- out_ready  in  1  consumer accepts the current term
- out_valid  out  1  out_data is a valid term
- out_data  out  WIDTH  current term
- out_index  out  IDX_W  index of out_data since the last seed/wrap; wraps modulo 2^IDX_W
- wrap  out  1  qualifies out_data as the last representable term before a restart; only meaningful while out_valid=1

## Operation
- Internal state:
  - seed registers sa, sb
  - term pair a (next to emit), b (following term)
  - ovf flag: b is not representable
  - index counter
- Reset values:
  - sa=a=SEED_A, sb=b=SEED_B, ovf=0
  - out_valid=0, out_data=0, out_index=0, wrap=0
  - state IDLE
- States:
  - IDLE: out_valid=0.
  - VALID: term presented.
  - DONE: only exists with FIBO_HOLD_EN.
- The term is advanced ("advance") when:
  - in IDLE with en=1, or
  - in VALID with en=1 and out_ready=1.
- On an advance:
  - out_data<=a, wrap<=ovf, out_valid<=1, out_index<=index.
  - If ovf=0: a<=b, b<=(a+b)[WIDTH-1:0], ovf<=carry out of the WIDTH+1-bit sum a+b, index<=index+1.
  - If ovf=1 (the emitted term is the last one): a<=sa, b<=sb, ovf<=0, index<=0.
- Other transitions:
  - VALID with out_ready=1 and en=0: go to IDLE, out_valid<=0. out_data, out_index and wrap hold their values.
  - VALID with out_ready=0: hold all outputs and state (stall); en is ignored.
- load=1 has priority over every other input in every state:
  - sa<=seed_a, sb<=seed_b, a<=seed_a, b<=seed_b, ovf<=0, index<=0.
  - out_valid<=0, wrap<=0, go to IDLE.
  - A presented term that has not been accepted is discarded.
- Arithmetic is unsigned. Only the ovf flag detects overflow; a truncated sum is never emitted.

## Timing
- Latency: en asserted in IDLE produces out_valid=1 on the next rising edge.
- Throughput: one term per cycle while en=1 and out_ready=1.
- Handshake: a term transfers on a clock edge where out_valid=1 and out_ready=1. out_data, out_index and wrap are stable while out_valid=1 and out_ready=0.
- load in the same cycle as a transfer: the transfer completes for the consumer, the load takes effect, and the next term is seed_a.
- Reset is asynchronous and may occur mid-stream. All registers return to their reset values immediately. The first term after reset release is SEED_A.

## Configuration
- FIBO_HOLD_EN defined:
  - After the term emitted with wrap=1 is accepted, go to DONE.
  - DONE: out_valid=0, en ignored.
  - DONE is left only via load or reset.
- FIBO_HOLD_EN undefined:
  - The sequence restarts from sa, sb immediately after the wrap term.
  - The DONE state is not built.

## Test plan
- Reset, then en=1, out_ready=1, WIDTH=16, seeds 0,1:
  - Terms 0,1,1,2,...,28657,46368 with out_index 0..24.
  - wrap=1 only on 46368 (index 24).
  - The next term is 0 with index 0.
- Same setup, but out_ready=0 for 3 cycles while term 13 is presented:
  - 13 and index 7 are held for 3 cycles.
  - 21 follows on the first cycle with out_ready=1.
- load with seeds 2,1 (Lucas) during a stall:
  - out_valid=0 on the next cycle.
  - Then en=1 gives 2,1,3,4,7,11 with index 0..5.
- WIDTH=8, seeds 0,1, free-running:
  - Terms end with 233 flagged wrap=1 (144+233 overflows).
  - With FIBO_HOLD_EN: out_valid stays 0 until load.
  - Without FIBO_HOLD_EN: the next term is 0.
- Assert reset asynchronously mid-cycle while streaming term 55:
  - out_valid, out_data and out_index go to 0 immediately.
  - After release plus en, the first term is SEED_A.
- en toggling 1,0,1 with out_ready=1:
  - out_valid goes 1,0,1.
  - Consecutive terms are 0 then 1; no term is skipped or repeated.
